// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin byte arbiter and burst sequencer for one shared UART transmitter
// Optional per-grant ID header byte: UART_TX_ARB_ID_HDR_EN
module uart_tx_arbiter #(
  parameter int N            = 4,
  parameter int BUSY_TIMEOUT = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   last,
  input  logic [8*N-1:0] data,
  input  logic           pen_cfg,
  input  logic           peven_cfg,
  output logic [N-1:0]   ack,
  output logic [N-1:0]   grant,
  output logic           tx_en,
  output logic [7:0]     tx_din,
  output logic           tx_pen,
  output logic           tx_peven,
  input  logic           tx_busy,
  output logic           err
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

`ifdef UART_TX_ARB_ID_HDR_EN
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, HDR} state_t;
`else
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;
`endif

  state_t          state, state_n;
  logic [IW-1:0]   idx, idx_n;
  logic [IW-1:0]   lastg, lastg_n;
  logic [IW-1:0]   sel;
  logic            found;
  logic            last_r, last_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [N-1:0]    ack_n, grant_n;
  logic            tx_en_n, tx_pen_n, tx_peven_n, err_n;
  logic [7:0]      tx_din_n;
  logic            more;
`ifdef UART_TX_ARB_ID_HDR_EN
  logic            hdr_r, hdr_n;
`endif

  // first requesting index after the previous owner, wrapping
  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (!found && req[(int'(lastg) + k) % N]) begin
        sel   = IW'((int'(lastg) + k) % N);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_n    = state;
    idx_n      = idx;
    lastg_n    = lastg;
    last_n     = last_r;
    cnt_n      = cnt;
    grant_n    = grant;
    ack_n      = '0;
    tx_en_n    = 1'b0;
    tx_din_n   = tx_din;
    tx_pen_n   = tx_pen;
    tx_peven_n = tx_peven;
    err_n      = 1'b0;
    more       = !last_r && req[idx];
`ifdef UART_TX_ARB_ID_HDR_EN
    hdr_n      = hdr_r;
    more       = hdr_r || (!last_r && req[idx]);
`endif
    case (state)
      IDLE: begin
        if (|req) begin
          idx_n      = sel;
          grant_n    = N'(1) << sel;
          tx_pen_n   = pen_cfg;
          tx_peven_n = peven_cfg;
          tx_en_n    = 1'b1;
`ifdef UART_TX_ARB_ID_HDR_EN
          tx_din_n   = {5'b10100, 3'(sel)};
          hdr_n      = 1'b1;
          state_n    = HDR;
`else
          tx_din_n   = data[8*sel +: 8];
          ack_n      = N'(1) << sel;
          last_n     = last[sel];
          state_n    = ISSUE;
`endif
        end
      end
`ifdef UART_TX_ARB_ID_HDR_EN
      HDR: begin
        cnt_n   = '0;
        state_n = WAIT_BUSY;
      end
`endif
      ISSUE: begin
        cnt_n   = '0;
        state_n = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_n = WAIT_DONE;
        end else if (cnt == CW'(BUSY_TIMEOUT - 1)) begin
          // acked byte is dropped, not retried
          err_n   = 1'b1;
          grant_n = '0;
          lastg_n = idx;
          state_n = IDLE;
`ifdef UART_TX_ARB_ID_HDR_EN
          hdr_n   = 1'b0;
`endif
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          if (more) begin
            tx_din_n = data[8*idx +: 8];
            ack_n    = N'(1) << idx;
            last_n   = last[idx];
            tx_en_n  = 1'b1;
            state_n  = ISSUE;
`ifdef UART_TX_ARB_ID_HDR_EN
            hdr_n    = 1'b0;
`endif
          end else begin
            grant_n = '0;
            lastg_n = idx;
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      idx      <= '0;
      lastg    <= IW'(N - 1);
      last_r   <= 1'b0;
      cnt      <= '0;
      grant    <= '0;
      ack      <= '0;
      tx_en    <= 1'b0;
      tx_din   <= '0;
      tx_pen   <= 1'b0;
      tx_peven <= 1'b0;
      err      <= 1'b0;
`ifdef UART_TX_ARB_ID_HDR_EN
      hdr_r    <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      lastg    <= lastg_n;
      last_r   <= last_n;
      cnt      <= cnt_n;
      grant    <= grant_n;
      ack      <= ack_n;
      tx_en    <= tx_en_n;
      tx_din   <= tx_din_n;
      tx_pen   <= tx_pen_n;
      tx_peven <= tx_peven_n;
      err      <= err_n;
`ifdef UART_TX_ARB_ID_HDR_EN
      hdr_r    <= hdr_n;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter with a busy-flag transmitter model
module tb_uart_tx_arbiter;
  localparam int N     = 4;
  localparam int FRAME = 12;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req, last, ack, grant;
  logic [8*N-1:0] data;
  logic           pen_cfg, peven_cfg;
  logic           tx_en, tx_pen, tx_peven, tx_busy, err;
  logic [7:0]     tx_din;
  logic           stuck;
  int             bcnt;

  int vecs = 0;
  int fails = 0;
  int n_err = 0;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] din;
    logic       pen;
    logic       peven;
    logic       ackf;
    logic       cont;
  } exp_t;

  exp_t       expq[$];
  logic [8:0] rq[N][$];

  uart_tx_arbiter #(.N(N), .BUSY_TIMEOUT(3)) dut (
    .clk(clk), .rst(rst), .req(req), .last(last), .data(data),
    .pen_cfg(pen_cfg), .peven_cfg(peven_cfg), .ack(ack), .grant(grant),
    .tx_en(tx_en), .tx_din(tx_din), .tx_pen(tx_pen), .tx_peven(tx_peven),
    .tx_busy(tx_busy), .err(err)
  );

  always #5 clk = ~clk;

  // transmitter stand-in: busy rises the cycle after en, holds FRAME cycles
  always @(posedge clk) begin
    if (!rst) begin
      tx_busy <= 1'b0;
      bcnt    <= 0;
    end else if (tx_busy) begin
      if (bcnt == 1) tx_busy <= 1'b0;
      bcnt <= bcnt - 1;
    end else if (tx_en && !stuck) begin
      tx_busy <= 1'b1;
      bcnt    <= FRAME;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_exp(input int id, input logic [7:0] din, input logic pen,
                          input logic peven, input logic ackf, input logic cont);
    exp_t e;
    e.id = 2'(id); e.din = din; e.pen = pen; e.peven = peven; e.ackf = ackf; e.cont = cont;
    expq.push_back(e);
  endtask

  task automatic expect_data(input int id, input logic [7:0] din, input logic pen,
                             input logic peven, input logic newg);
`ifdef UART_TX_ARB_ID_HDR_EN
    if (newg) push_exp(id, 8'hA0 | 8'(id), pen, peven, 1'b0, 1'b0);
    push_exp(id, din, pen, peven, 1'b1, 1'b1);
`else
    push_exp(id, din, pen, peven, 1'b1, !newg);
`endif
  endtask

  // monitor: pops one expected frame per tx_en
  int cyc = 0, fall_cyc = 0, en_cyc = 0;
  logic busy_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    logic [3:0] oh;
    cyc++;
    if (rst === 1'b1) begin
      if (busy_prev && !tx_busy) fall_cyc = cyc;
      busy_prev = tx_busy;
      if (tx_en) begin
        chk("en_while_busy", 32'(tx_busy), 0);
        chk("tx_en_expected", 32'(expq.size() != 0), 1);
        if (expq.size() != 0) begin
          e  = expq.pop_front();
          oh = 4'b1 << e.id;
          chk("grant", 32'(grant), 32'(oh));
          chk("tx_din", 32'(tx_din), 32'(e.din));
          chk("tx_pen", 32'(tx_pen), 32'(e.pen));
          chk("tx_peven", 32'(tx_peven), 32'(e.peven));
          chk("ack", 32'(ack), e.ackf ? 32'(oh) : 0);
          if (e.cont) chk("gap_cont", 32'(cyc - fall_cyc), 1);
          else        chk("gap_new_ge2", 32'(cyc - fall_cyc >= 2), 1);
        end
        en_cyc = cyc;
      end
      if (err) begin
        n_err++;
        chk("err_delay", 32'(cyc - en_cyc), 4);
        chk("err_grant", 32'(grant), 0);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < N; i++)
      if (ack[i] && rq[i].size() > 0) rq[i].delete(0);
    for (int i = 0; i < N; i++) begin
      if (rq[i].size() > 0) begin
        {last[i], data[8*i +: 8]} = rq[i][0];
        req[i] = 1'b1;
      end else begin
        req[i] = 1'b0;
      end
    end
  endtask

  function automatic logic all_idle();
    logic r;
    r = (expq.size() == 0) && (grant == '0) && !tx_busy;
    for (int i = 0; i < N; i++) if (rq[i].size() != 0) r = 1'b0;
    return r;
  endfunction

  task automatic drain(input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      tick();
      if (all_idle()) break;
    end
    chk("drain_in_budget", 32'(k < budget), 1);
    chk("grant_idle", 32'(grant), 0);
    chk("scoreboard_empty", 32'(expq.size()), 0);
  endtask

  initial begin
    int k;
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int k;
    rst = 1'b0; req = '0; last = '0; data = '0;
    pen_cfg = 1'b0; peven_cfg = 1'b0; stuck = 1'b0;

    // reset with all requesters pending, then round robin 0,1,2,3,0
    rq[0].push_back({1'b1, 8'h10}); rq[0].push_back({1'b1, 8'h14});
    rq[1].push_back({1'b1, 8'h11});
    rq[2].push_back({1'b1, 8'h12});
    rq[3].push_back({1'b1, 8'h13});
    repeat (3) begin
      tick();
      chk("rst_tx_en", 32'(tx_en), 0);
      chk("rst_ack", 32'(ack), 0);
      chk("rst_grant", 32'(grant), 0);
      chk("rst_err", 32'(err), 0);
    end
    expect_data(0, 8'h10, 0, 0, 1);
    expect_data(1, 8'h11, 0, 0, 1);
    expect_data(2, 8'h12, 0, 0, 1);
    expect_data(3, 8'h13, 0, 0, 1);
    expect_data(0, 8'h14, 0, 0, 1);
    rst = 1'b1;
    drain(600);

    // single byte, one-cycle latency from req
    pen_cfg = 1'b1; peven_cfg = 1'b1;
    rq[2].push_back({1'b1, 8'hA5});
    expect_data(2, 8'hA5, 1, 1, 1);
    tick();
    tick();
    chk("single_tx_en", 32'(tx_en), 1);
    chk("single_pen", 32'(tx_pen), 1);
    chk("single_peven", 32'(tx_peven), 1);
`ifdef UART_TX_ARB_ID_HDR_EN
    chk("single_din", 32'(tx_din), 32'h A2);
    chk("single_ack", 32'(ack), 0);
`else
    chk("single_din", 32'(tx_din), 32'hA5);
    chk("single_ack", 32'(ack), 32'b0100);
`endif
    drain(300);

    // burst on requester 1 while 3 waits; parity changes mid-burst are ignored
    pen_cfg = 1'b1; peven_cfg = 1'b0;
    rq[1].push_back({1'b0, 8'h11});
    rq[1].push_back({1'b0, 8'h22});
    rq[1].push_back({1'b1, 8'h33});
    expect_data(1, 8'h11, 1, 0, 1);
    expect_data(1, 8'h22, 1, 0, 0);
    expect_data(1, 8'h33, 1, 0, 0);
    tick();
    tick();
    pen_cfg = 1'b0; peven_cfg = 1'b1;
    rq[3].push_back({1'b1, 8'h44});
    expect_data(3, 8'h44, 0, 1, 1);
    drain(600);

    // burst abandoned when req drops without last
    pen_cfg = 1'b0; peven_cfg = 1'b0;
    rq[0].push_back({1'b0, 8'h55});
    expect_data(0, 8'h55, 0, 0, 1);
    drain(300);
    chk("no_err_yet", 32'(n_err), 0);

    // busy never rises: timeout on requester 2, then 3 is served
    stuck = 1'b1;
    rq[2].push_back({1'b1, 8'h66});
    rq[3].push_back({1'b1, 8'h77});
`ifdef UART_TX_ARB_ID_HDR_EN
    push_exp(2, 8'hA2, 0, 0, 1'b0, 1'b0);
    expect_data(3, 8'h77, 0, 0, 1);
    expect_data(2, 8'h66, 0, 0, 1);
`else
    expect_data(2, 8'h66, 0, 0, 1);
    expect_data(3, 8'h77, 0, 0, 1);
`endif
    for (k = 0; k < 100; k++) begin
      tick();
      if (n_err >= 1) break;
    end
    chk("timeout_seen", 32'(k < 100), 1);
    stuck = 1'b0;
    drain(600);
    chk("err_count", 32'(n_err), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter and sequencer that shares one `UartTransmitter` between N byte-producing requesters. It owns the transmitter's `en`/`din`/`pen`/`peven` inputs and watches its `busy` flag. It supports multi-byte bursts, in which a requester keeps the link until it sends a byte marked `last`. It sits between the on-chip producers (debug, status and log sources) and the single physical TX pin.

## Interface
Parameters:
- `N`, default 4: number of requesters, legal range 2..8.
- `BUSY_TIMEOUT`, default 3: cycles allowed after `tx_en` for `tx_busy` to rise.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, synchronous, active-low.
- `req`, in, N: per-requester byte valid. Held until `ack`.
- `last`, in, N: marks the requester's current byte as the end of its burst.
- `data`, in, 8*N: flattened bytes; requester i uses bits [8i+7:8i].
- `pen_cfg`, in, 1: parity enable. Sampled at grant.
- `peven_cfg`, in, 1: even parity select. Sampled at grant.
- `ack`, out, N: one-cycle pulse; the byte is accepted and `data`/`last` may change next cycle.
- `grant`, out, N: one-hot current owner, 0 when idle.
- `tx_en`, out, 1: one-cycle start pulse to the transmitter.
- `tx_din`, out, 8: byte to the transmitter.
- `tx_pen`, out, 1: to the transmitter's `pen`.
- `tx_peven`, out, 1: to the transmitter's `peven`.
- `tx_busy`, in, 1: from the transmitter's `busy`.
- `err`, out, 1: one-cycle pulse on busy timeout.

## Operation
- All outputs are registered. Reset value is 0 for every output. The round-robin pointer `lastg` resets to N-1, so requester 0 has highest priority first.
- States:
  - IDLE
  - ISSUE (one cycle, `tx_en`=1)
  - WAIT_BUSY
  - WAIT_DONE
  - HDR: only with the macro; see Configuration.
- **IDLE:**
  - If `req`≠0, select the first set bit searching from (`lastg`+1) mod N upward with wrap.
  - Register `grant`, `tx_din`, `tx_pen`←`pen_cfg`, `tx_peven`←`peven_cfg`, `tx_en`←1 and `ack`←onehot; record `last` of the selected requester; go to ISSUE.
- **ISSUE:** `tx_en`←0, `ack`←0, counter←0; go to WAIT_BUSY.
- **WAIT_BUSY:**
  - `tx_busy`=1 → WAIT_DONE.
  - Otherwise increment the counter. When the counter reaches `BUSY_TIMEOUT`: `err`←1, `grant`←0, `lastg`←selected requester, go to IDLE.
  - The byte already acked is not resent.
- **WAIT_DONE:** when `tx_busy`=0:
  - If the recorded `last`=0 and `req[grant]`=1: issue the next byte exactly as in IDLE, keeping `grant` and the latched parity; go to ISSUE.
  - Otherwise: `grant`←0, `lastg`←owner, go to IDLE.
  - Case where `last`=0 but `req` has dropped: the burst is abandoned and the grant released. This is not an error.
- `req` bits that change during a grant have no effect until the next arbitration.
- `pen_cfg`/`peven_cfg` changes mid-burst are ignored until the next grant.

## Timing
- `req` seen in IDLE cycle c → `tx_en`, `ack` and `grant` high in cycle c+1.
- `tx_busy` is high in c+2 (the transmitter samples `en` at the end of c+1).
- Byte-to-byte gap within a burst: `tx_busy` low first seen in cycle d → `tx_en` in d+1. Zero idle cycles are inserted beyond the transmitter's own IDLE cycle.
- Between owners, one extra IDLE cycle: `tx_busy` low in d → IDLE at d+1 → `tx_en` at d+2.
- `tx_din` is held stable from ISSUE until the next issue.
- `tx_en` is never high for two consecutive cycles. It is never asserted while `tx_busy`=1.
- Reset mid-operation: next cycle all outputs are 0, the state is IDLE and `lastg`=N-1. The transmitter shares `rst`, so no stale frame continues.
- Simultaneous `err` and new requests: the pending `req` is arbitrated on the next IDLE cycle.

## Configuration
- Macro: `UART_TX_ARB_ID_HDR_EN`.
- **Defined:** every new grant (not burst continuations) first sends the header byte {5'b10100, id[2:0]}.
  - Path: IDLE→HDR, with `tx_en`=1 and `ack`=0.
  - The arbiter then waits on busy rise and fall exactly as for data (same timeout).
  - It then issues the requester's first data byte with `ack`.
  - A timeout during the header releases the grant without `ack`.
- **Undefined:** no HDR state; data bytes go out directly.

## Test plan
- Reset: hold `rst`=0 for 3 cycles with `req`=4'b1111 → `tx_en`, `ack`, `grant` and `err` all 0. After release, the first grant is 4'b0001.
- Single byte: `req[2]`=1, `data[2]`=8'hA5, `last[2]`=1, `pen_cfg`=1, `peven_cfg`=1.
  - `tx_en`, `ack[2]` and `tx_din`=8'hA5 appear one cycle later; `tx_pen`=`tx_peven`=1.
  - With the real `UartTransmitter` at CLK_FREQ_HZ=1e6 and BAUDRATE=1e5, the serial output decodes to A5 with parity 0. `grant` clears after busy falls.
- Round robin: all four `req` held high with `last`=1 → grant order 0,1,2,3,0, with exactly one `tx_en` per byte.
- Burst: requester 1 sends 8'h11, 8'h22, 8'h33 (`last` on the third) while `req[3]`=1 → three consecutive frames for requester 1, then requester 3. The gap between 11/22/33 is one transmitter IDLE cycle.
- Timeout: busy model stuck at 0 → `err` pulses exactly 4 cycles after `tx_en` with `BUSY_TIMEOUT`=3; `grant` returns to 0 and the next requester is served.
- With `UART_TX_ARB_ID_HDR_EN`: requester 2 sends 8'h5C → frames 8'hA2 then 8'h5C; `ack[2]` pulses only with the second `tx_en`.
